// File: rtl/ss_io_pkg.sv
// ss_io_pkg: shared definitions for the ss_io stack bus.
//   ss_ops - one operation per clock presented to the stack:
//            SS_LOAD (idle / hold), SS_PUSH (push vi), SS_POP (drop top).
package ss_io_pkg;

    typedef enum logic [1:0] {
        SS_LOAD = 2'd0,
        SS_PUSH = 2'd1,
        SS_POP  = 2'd2
    } ss_ops;

endpackage

// File: rtl/ss_seq_pkg.sv
// ss_seq_pkg: command set, error codes and per-command lookup tables for the
// stack sequencer.
//   ss_cmd_e   - Forth primitives accepted on the cmd port
//   ss_err_e   - completion status reported with done
//   ss_vsel_e  - source of the value driven on vi for a PUSH
//   seq_need   - elements that must be present before the command runs
//   seq_growth - net change in depth after the command completes
//   seq_nops   - number of bus ops in the command's micro-sequence
package ss_seq_pkg;

    typedef enum logic [2:0] {
        SQ_NOP  = 3'd0,
        SQ_LIT  = 3'd1,
        SQ_DROP = 3'd2,
        SQ_DUP  = 3'd3,
        SQ_SWAP = 3'd4,
        SQ_OVER = 3'd5,
        SQ_ROT  = 3'd6
    } ss_cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2
    } ss_err_e;

    typedef enum logic [2:0] {
        VS_LIT = 3'd0,
        VS_S0  = 3'd1,
        VS_A   = 3'd2,
        VS_B   = 3'd3,
        VS_C   = 3'd4
    } ss_vsel_e;

    function automatic logic [1:0] seq_need(input ss_cmd_e c);
        case (c)
            SQ_DROP, SQ_DUP:  return 2'd1;
            SQ_SWAP, SQ_OVER: return 2'd2;
            SQ_ROT:           return 2'd3;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic logic signed [1:0] seq_growth(input ss_cmd_e c);
        case (c)
            SQ_LIT, SQ_DUP, SQ_OVER: return 2'sb01;
            SQ_DROP:                 return 2'sb11;
            default:                 return 2'sb00;
        endcase
    endfunction

    function automatic logic [2:0] seq_nops(input ss_cmd_e c);
        case (c)
            SQ_LIT, SQ_DROP, SQ_DUP: return 3'd1;
            SQ_SWAP:                 return 3'd4;
            SQ_OVER:                 return 3'd3;
            SQ_ROT:                  return 3'd6;
            default:                 return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ss_io.sv
// ss_io: stack bus between a sequencer (master) and a data stack (slave).
//   op - operation for this cycle (master -> stack)
//   vi - value pushed by SS_PUSH (master -> stack)
//   sp - current stack pointer (stack -> master)
//   s0 - current top of stack (stack -> master)
interface ss_io
    import ss_io_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32
);
    localparam int AW = $clog2(DEPTH);

    ss_ops            op;
    logic [DSZ-1:0]   vi;
    logic [AW-1:0]    sp;
    logic [DSZ-1:0]   s0;

    modport master (output op, output vi, input sp, input s0);
    modport slave  (input op, input vi, output sp, output s0);
endinterface

// File: rtl/ss_seq_useq.sv
// ss_useq: combinational micro-sequence ROM for the stack sequencer.
// Inputs:  cmd  - latched command
//          step - index of the op within the command's sequence
// Outputs: op    - bus op for this step
//          vsel  - source of vi when op is SS_PUSH
//          cap   - capture enables for scratch registers {C,B,A}; the
//                  capture samples s0 in the same cycle the op is driven,
//                  i.e. before a POP in that cycle has taken effect
//          last  - this step is the final op of the sequence
module ss_useq
    import ss_io_pkg::*;
    import ss_seq_pkg::*;
(
    input  ss_cmd_e     cmd,
    input  logic [2:0]  step,
    output ss_ops       op,
    output ss_vsel_e    vsel,
    output logic [2:0]  cap,
    output logic        last
);

    always_comb begin
        op   = SS_LOAD;
        vsel = VS_LIT;
        cap  = 3'b000;
        last = (step == (seq_nops(cmd) - 3'd1));
        case (cmd)
            SQ_LIT: begin
                op   = SS_PUSH;
                vsel = VS_LIT;
            end
            SQ_DROP: op = SS_POP;
            SQ_DUP: begin
                op   = SS_PUSH;
                vsel = VS_S0;
            end
            SQ_SWAP: begin
                case (step)
                    3'd0: begin op = SS_POP;  cap = 3'b001; end
                    3'd1: begin op = SS_POP;  cap = 3'b010; end
                    3'd2: begin op = SS_PUSH; vsel = VS_A;  end
                    3'd3: begin op = SS_PUSH; vsel = VS_B;  end
                    default: ;
                endcase
            end
            SQ_OVER: begin
                // B is captured while A is being pushed back: s0 then
                // shows the second element after the first POP.
                case (step)
                    3'd0: begin op = SS_POP;  cap = 3'b001; end
                    3'd1: begin op = SS_PUSH; vsel = VS_A; cap = 3'b010; end
                    3'd2: begin op = SS_PUSH; vsel = VS_B; end
                    default: ;
                endcase
            end
            SQ_ROT: begin
                case (step)
                    3'd0: begin op = SS_POP;  cap = 3'b001; end
                    3'd1: begin op = SS_POP;  cap = 3'b010; end
                    3'd2: begin op = SS_POP;  cap = 3'b100; end
                    3'd3: begin op = SS_PUSH; vsel = VS_B;  end
                    3'd4: begin op = SS_PUSH; vsel = VS_A;  end
                    3'd5: begin op = SS_PUSH; vsel = VS_C;  end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ss_seq.sv
// ss_seq: stack-bus master that runs Forth stack primitives as sequences of
// single-cycle SS_PUSH/SS_POP ops on an ss_io bus.
// Ports:
//   clk   - clock (the attached stack commits on the falling edge)
//   rst   - synchronous active-low reset
//   req   - command valid, taken only while busy=0
//   cmd   - ss_cmd_e encoding; unknown codes run as SQ_NOP
//   lit   - literal for SQ_LIT, sampled when the command is taken
//   busy  - a command is in progress
//   done  - one-cycle completion pulse (also on error)
//   err   - ss_err_e status, held until the next command is taken
//   tos   - top of stack after the last completed command
//   depth - current number of stack elements
//   ss_if - stack bus (drives op/vi, reads s0)
module ss_seq
    import ss_io_pkg::*;
    import ss_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int DW    = $clog2(DEPTH) + 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [2:0]      cmd,
    input  logic [DSZ-1:0]  lit,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err,
    output logic [DSZ-1:0]  tos,
    output logic [DW-1:0]   depth,
    ss_io.master            ss_if
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]      state_reg;
    logic [2:0]      step_reg;
    ss_cmd_e         cmd_reg;
    logic [DSZ-1:0]  lit_reg;
    logic [DSZ-1:0]  cap_reg [3];    // scratch A, B, C
    logic [DW-1:0]   depth_reg;
    logic [DSZ-1:0]  tos_reg;
    ss_err_e         err_reg;
    logic            done_reg;
    ss_ops           op_reg;
    logic [DSZ-1:0]  vi_reg;

    ss_ops           u_op;
    ss_vsel_e        u_vsel;
    logic [2:0]      u_cap;
    logic            u_last;
    logic [DSZ-1:0]  vi_src;

    logic            cmd_known;
    logic [DW-1:0]   need_w;
    logic signed [1:0] grow_w;
    logic [DW:0]     depth_after;
    logic            under_w;
    logic            over_w;

    ss_useq u_useq (
        .cmd  (cmd_reg),
        .step (step_reg),
        .op   (u_op),
        .vsel (u_vsel),
        .cap  (u_cap),
        .last (u_last)
    );

    // NOP and unused encodings skip CHECK/EXEC entirely.
    assign cmd_known = (cmd >= 3'd1) && (cmd <= 3'd6);

    // Depth is held in DW+1 bits so a DROP on an empty stack cannot alias
    // into a legal value; underflow is tested first anyway.
    assign need_w      = DW'(seq_need(cmd_reg));
    assign grow_w      = seq_growth(cmd_reg);
    assign depth_after = {1'b0, depth_reg} + {{(DW-1){grow_w[1]}}, grow_w};
    assign under_w     = depth_reg < need_w;
    assign over_w      = depth_after > (DW+1)'(DEPTH-1);

    always_comb begin
        case (u_vsel)
            VS_LIT:  vi_src = lit_reg;
            VS_S0:   vi_src = ss_if.s0;
            VS_A:    vi_src = cap_reg[0];
            VS_B:    vi_src = cap_reg[1];
            VS_C:    vi_src = cap_reg[2];
            default: vi_src = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cap
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cap_reg[gi] <= '0;
                end else if (state_reg == ST_EXEC && u_cap[gi]) begin
                    cap_reg[gi] <= ss_if.s0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= 3'd0;
            cmd_reg   <= SQ_NOP;
            lit_reg   <= '0;
            depth_reg <= '0;
            tos_reg   <= '0;
            err_reg   <= ERR_NONE;
            done_reg  <= 1'b0;
            op_reg    <= SS_LOAD;
            vi_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            op_reg   <= SS_LOAD;
            vi_reg   <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        cmd_reg   <= cmd_known ? ss_cmd_e'(cmd) : SQ_NOP;
                        lit_reg   <= lit;
                        err_reg   <= ERR_NONE;
                        state_reg <= cmd_known ? ST_CHECK : ST_FIN;
                    end
                end
                ST_CHECK: begin
                    step_reg <= 3'd0;
                    if (under_w) begin
                        err_reg   <= ERR_UNDER;
                        state_reg <= ST_FIN;
                    end else if (over_w) begin
                        err_reg   <= ERR_OVER;
                        state_reg <= ST_FIN;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    op_reg <= u_op;
                    vi_reg <= vi_src;
                    if (u_op == SS_PUSH) begin
                        depth_reg <= depth_reg + 1'b1;
                    end else if (u_op == SS_POP) begin
                        depth_reg <= depth_reg - 1'b1;
                    end
                    if (u_last) begin
                        state_reg <= ST_FIN;
                    end else begin
                        step_reg <= step_reg + 3'd1;
                    end
                end
                ST_FIN: begin
                    // The last op committed on the previous falling edge,
                    // so s0 already shows the final top of stack.
                    done_reg  <= 1'b1;
                    tos_reg   <= ss_if.s0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign err      = err_reg;
    assign tos      = tos_reg;
    assign depth    = depth_reg;
    assign ss_if.op = op_reg;
    assign ss_if.vi = vi_reg;

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Initiator/master side of the ss_io stack bus. Executes Forth stack primitives (DUP, DROP, SWAP, OVER, ROT, PUSH literal) as timed sequences of single-cycle SS_PUSH/SS_POP ops.
- Sits between the inner-interpreter decode and the data stack instance.
- Tracks stack depth and flags underflow/overflow before touching the stack.
- Returns TOS and a one-cycle done pulse per command.

Parameters:
- DEPTH, 64, stack depth. Must match the attached stack.
- DSZ, 32, data width.
- DW, $clog2(DEPTH)+1, width of the internal depth counter. Derived; do not override.

Ports:
- clk  input  1  clock. Posedge domain; the stack acts on negedge.
- rst  input  1  synchronous, active-low reset.
- req  input  1  command valid. Accepted only when busy=0.
- cmd  input  3  ss_cmd_e: SQ_NOP, SQ_LIT, SQ_DROP, SQ_DUP, SQ_SWAP, SQ_OVER, SQ_ROT.
- lit  input  DSZ  literal for SQ_LIT. Sampled at acceptance.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse when a command completes or errors.
- err  output  2  ss_err_e: ERR_NONE, ERR_UNDER, ERR_OVER. Valid with done; held until the next acceptance.
- tos  output  DSZ  copy of ss_if.s0 after the last completed command.
- depth  output  DW  current element count.
- ss_if  ss_io  -  drives op and vi; reads sp and s0.

Behaviour:
- Reset (rst=0 at posedge):
  - busy=0, done=0, err=ERR_NONE, depth=0, tos=0.
  - ss_if.op=SS_LOAD, ss_if.vi=0, FSM=IDLE, step=0.
  - Reset mid-sequence abandons the sequence. The stack is not restored.
- Bus timing:
  - The sequencer drives op/vi for exactly one clk cycle per op.
  - The stack commits on the following negedge.
  - ss_if.s0 reflects the op at the next posedge.
  - At most one op per cycle. SS_LOAD at all other times.
- FSM states: IDLE, CHECK, EXEC, FIN.
- IDLE:
  - req=1 latches cmd/lit, clears err, goes to CHECK. busy rises the next cycle.
  - SQ_NOP goes straight to FIN.
- CHECK (1 cycle): compare depth against need(cmd) and growth(cmd).
  - need: LIT 0, DROP 1, DUP 1, SWAP 2, OVER 2, ROT 3.
  - growth: LIT +1, DROP -1, DUP +1, SWAP 0, OVER +1, ROT 0.
  - depth<need → err=ERR_UNDER, go to FIN, no ops issued.
  - depth+growth>DEPTH-1 → err=ERR_OVER, go to FIN, no ops issued.
  - Otherwise → EXEC, step=0.
- EXEC: step counter indexes the micro-sequence. Registers A, B, C capture s0 before each pop.
  - LIT: PUSH lit. 1 op.
  - DROP: POP. 1 op.
  - DUP: PUSH s0. 1 op.
  - SWAP: A=s0,POP; B=s0,POP; PUSH A; PUSH B. 4 ops.
  - OVER: A=s0,POP; B=s0,PUSH A; PUSH B. 3 ops.
  - ROT: A=s0,POP; B=s0,POP; C=s0,POP; PUSH B; PUSH A; PUSH C. 6 ops.
  - depth updates by ±1 on each issued PUSH/POP, in the same cycle the op is driven.
- FIN (1 cycle): done=1; tos=ss_if.s0; FSM→IDLE; busy falls with done.
- Latency: req to done = ops+2 cycles. Back-to-back: the next req is accepted in the cycle after done.
- req while busy=1 is ignored; no queueing. The upstream holds req until busy=0.
- depth counts 0..DEPTH-1. sp wraps in the stack itself. The sequencer must never issue an op that would wrap; CHECK guarantees this.
- Invalid cmd encodings behave as SQ_NOP.

Decomposition:
- Package ss_seq_pkg: ss_cmd_e, ss_err_e, the need/growth lookup functions, and per-cmd op count.
- ss_ops (SS_PUSH/SS_POP/SS_LOAD) stays in the existing interface package; it is reused, not redefined.
- One sub-module, ss_useq:
  - Combinational micro-sequence ROM, indexed by (cmd, step).
  - Returns op, vi source select (lit/s0/A/B/C), capture-enable for A/B/C, and last.
  - Keeps the FSM file small.

Test Plan:
- Reset, then LIT 5, LIT 7 → done each after 3 cycles; tos=7, depth=2, two SS_PUSH seen on the bus.
- From [5 7], SWAP → 4 ops (POP,POP,PUSH 7,PUSH 5), done at cycle 6; tos=5, depth=2, then DROP gives tos=7.
- From [1 2 3], ROT → 6 ops; stack [2 3 1], tos=1, depth=3. OVER after that → [2 3 1 3], tos=3, depth=4.
- Empty stack, DROP → done after 2 cycles with err=ERR_UNDER; no op≠SS_LOAD issued; depth=0.
- Fill to depth DEPTH-1 with LITs, then DUP → err=ERR_OVER, depth unchanged; then DROP succeeds with err=ERR_NONE.
- Assert rst=0 during step 2 of ROT → next cycle busy=0, depth=0, op=SS_LOAD. req held high during busy is never double-accepted (count done pulses = accepted reqs).
